// File: rtl/cluster_compl_sync.sv
// cluster_compl_sync: per-VFU completion barrier across Ara clusters with skew-buffering pending counters
//   clk_i, rst_i   : clock, synchronous active-high reset
//   flush_i        : synchronous clear of all counters and overflow flags
//   pe_compl_i     : per-cluster, per-VFU completion pulses
//   pe_compl_o     : synchronized completion pulse, same for every cluster
//   busy_o         : any pending counter non-zero
//   overflow_o     : sticky per-cluster saturation flag
module cluster_compl_sync #(
    parameter int NrClusters = 4,
    parameter int NrVFUs     = 7,
    parameter int CntDepth   = 4,
    localparam int CntWidth  = $clog2(CntDepth + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [NrClusters-1:0][NrVFUs-1:0]   pe_compl_i,
    output logic [NrClusters-1:0][NrVFUs-1:0]   pe_compl_o,
    output logic                                busy_o,
    output logic [NrClusters-1:0]               overflow_o
);
    logic [NrClusters-1:0][NrVFUs-1:0][CntWidth-1:0] cnt_q, cnt_d;
    logic [NrClusters-1:0]                           ovf_q, ovf_d;
    logic [NrVFUs-1:0]                               fire;
    always_comb begin
        fire   = '1;
        busy_o = 1'b0;
        for (int c = 0; c < NrClusters; c++)
            for (int v = 0; v < NrVFUs; v++) begin
                fire[v] = fire[v] & (cnt_q[c][v] != '0);
                busy_o  = busy_o | (cnt_q[c][v] != '0);
            end
    end
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int c = 0; c < NrClusters; c++)
            for (int v = 0; v < NrVFUs; v++)
                // A pulse that coincides with a fire nets to zero, even at saturation.
                if (pe_compl_i[c][v] && !fire[v]) begin
                    if (cnt_q[c][v] == CntWidth'(CntDepth)) ovf_d[c] = 1'b1;
                    else cnt_d[c][v] = cnt_q[c][v] + CntWidth'(1);
                end else if (!pe_compl_i[c][v] && fire[v]) begin
                    cnt_d[c][v] = cnt_q[c][v] - CntWidth'(1);
                end
        if (flush_i) begin
            cnt_d = '0;
            ovf_d = '0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
    assign pe_compl_o = {NrClusters{fire}};
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_cluster_compl_sync.sv
// tb_cluster_compl_sync: directed vector bench for cluster_compl_sync (4-cluster and 1-cluster instances)
module tb_cluster_compl_sync;
    typedef logic [3:0][6:0] pv_t;
    typedef struct {
        pv_t        in;
        logic [6:0] fire;
        logic       busy;
    } vec_t;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    pv_t          pe_in = '0;
    pv_t          pe_out;
    logic         busy;
    logic [3:0]   ovf;
    logic [0:0][6:0] pe1_in = '0;
    logic [0:0][6:0] pe1_out;
    logic         busy1;
    logic [0:0]   ovf1;
    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    always #5 clk = ~clk;
    cluster_compl_sync #(.NrClusters(4), .NrVFUs(7), .CntDepth(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .pe_compl_i(pe_in),
        .pe_compl_o(pe_out), .busy_o(busy), .overflow_o(ovf)
    );
    cluster_compl_sync #(.NrClusters(1), .NrVFUs(7), .CntDepth(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .pe_compl_i(pe1_in),
        .pe_compl_o(pe1_out), .busy_o(busy1), .overflow_o(ovf1)
    );
    function automatic pv_t p(input logic [3:0] cm, input logic [6:0] vm);
        pv_t r;
        for (int c = 0; c < 4; c++) r[c] = cm[c] ? vm : 7'd0;
        return r;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic step(input logic fl, input logic rs, input pv_t in);
        flush = fl;
        rst   = rs;
        pe_in = in;
        @(posedge clk);
        #1;
        flush = 1'b0;
        rst   = 1'b0;
        pe_in = '0;
    endtask
    task automatic chk4(input string nm, input logic [6:0] f, input logic b, input logic [3:0] o);
        chk({nm, ".out"}, 32'(pe_out), 32'(pv_t'({4{f}})));
        chk({nm, ".busy"}, 32'(busy), 32'(b));
        chk({nm, ".ovf"}, 32'(ovf), 32'(o));
    endtask
    initial begin
        // single match: VFU 2, clusters at cycles 0,3,5,9
        for (int k = 0; k <= 10; k++)
            tbl.push_back('{(k == 0) ? p(4'b0001, 7'h04) : (k == 3) ? p(4'b0010, 7'h04) :
                            (k == 5) ? p(4'b0100, 7'h04) : (k == 9) ? p(4'b1000, 7'h04) : pv_t'(0),
                            (k == 9) ? 7'h04 : 7'h00, k != 10});
        // backlog drain: cluster 0 three times early, others three times late
        for (int k = 0; k <= 13; k++)
            tbl.push_back('{(k < 3) ? p(4'b0001, 7'h01) : (k >= 10 && k < 13) ? p(4'b1110, 7'h01) : pv_t'(0),
                            (k >= 10 && k < 13) ? 7'h01 : 7'h00, k != 13});
        // simultaneous increment and fire on VFU 1
        tbl.push_back('{p(4'b1111, 7'h02), 7'h02, 1'b1});
        tbl.push_back('{p(4'b0100, 7'h02), 7'h00, 1'b1});
        tbl.push_back('{pv_t'(0),          7'h00, 1'b1});
        tbl.push_back('{p(4'b1011, 7'h02), 7'h02, 1'b1});
        tbl.push_back('{pv_t'(0),          7'h00, 1'b0});
        // independent VFUs 0 and 5 completing together
        tbl.push_back('{p(4'b0011, 7'h21), 7'h00, 1'b1});
        tbl.push_back('{p(4'b1100, 7'h21), 7'h21, 1'b1});
        tbl.push_back('{pv_t'(0),          7'h00, 1'b0});

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk4("reset", 7'h00, 1'b0, 4'b0000);
        chk("reset.out1", 32'(pe1_out), 32'd0);
        chk("reset.busy1", 32'(busy1), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b0, 1'b0, tbl[i].in);
            chk4($sformatf("vec%0d", i), tbl[i].fire, tbl[i].busy, 4'b0000);
        end

        // overflow: cluster 3 VFU 4 five times, then others four times
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, p(4'b1000, 7'h10));
            chk4($sformatf("ovf_fill%0d", k), 7'h00, 1'b1, (k == 4) ? 4'b1000 : 4'b0000);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, (k < 4) ? p(4'b0111, 7'h10) : pv_t'(0));
            chk4($sformatf("ovf_drain%0d", k), (k < 4) ? 7'h10 : 7'h00, k < 4, 4'b1000);
        end

        // flush with pending counts and coincident inputs
        step(1'b0, 1'b0, p(4'b0001, 7'h01) | p(4'b0010, 7'h08));
        chk4("pre_flush", 7'h00, 1'b1, 4'b1000);
        step(1'b1, 1'b0, p(4'b1111, 7'h7f));
        chk4("flush", 7'h00, 1'b0, 4'b0000);
        step(1'b0, 1'b0, pv_t'(0));
        chk4("post_flush", 7'h00, 1'b0, 4'b0000);

        // reset mid-backlog with an overflow set and coincident inputs
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, p(4'b0001, 7'h02));
        step(1'b0, 1'b0, p(4'b0110, 7'h02));
        chk4("pre_rst", 7'h00, 1'b1, 4'b0001);
        step(1'b0, 1'b0, p(4'b1000, 7'h02));
        chk4("backlog", 7'h02, 1'b1, 4'b0001);
        step(1'b0, 1'b1, p(4'b1111, 7'h7f));
        chk4("rst", 7'h00, 1'b0, 4'b0000);
        step(1'b0, 1'b0, pv_t'(0));
        chk4("post_rst", 7'h00, 1'b0, 4'b0000);

        // degenerate single-cluster pass-through
        pe1_in = 7'h08;
        @(posedge clk);
        #1;
        pe1_in = '0;
        chk("deg.n1", 32'(pe1_out), 32'h08);
        chk("deg.busy", 32'(busy1), 32'd1);
        @(posedge clk);
        #1;
        chk("deg.n2", 32'(pe1_out), 32'h00);
        chk("deg.idle", 32'(busy1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
